// File: rtl/iq_capture_dl_pkg.sv
// Shared types and helpers for the deadlock report unit: FSM state encoding,
// priority index extraction and width computation.
package iq_capture_dl_pkg;

  localparam int MAX_VEC_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ORIGIN,
    ST_WALK,
    ST_REPORT,
    ST_DONE
  } dl_state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Lowest set bit wins so that simultaneous requests resolve deterministically.
  function automatic int lowest_set_index(input logic [MAX_VEC_W-1:0] vec);
    int idx;
    idx = 0;
    for (int i = MAX_VEC_W - 1; i >= 0; i--) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/iq_capture_dl_path_buf.sv
// Path buffer: records the process IDs visited by the token in write order
// and replays them one entry per read advance.
module iq_capture_dl_path_buf
  import iq_capture_dl_pkg::*;
#(
  parameter int PATH_DEPTH = 8,
  parameter int ID_W       = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            i_wrEn,
  input  logic [ID_W-1:0] i_wrData,
  input  logic            i_rdAdv,
  output logic [ID_W-1:0] o_rdData,
  output logic            o_rdIsLast,
  output logic            o_ovf
);

  localparam int PTR_W = clog2_min1(PATH_DEPTH);
  localparam int CNT_W = clog2_min1(PATH_DEPTH + 1);

  logic [ID_W-1:0]  r_mem [PATH_DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;
  logic             w_full;

  assign w_full     = (r_count == CNT_W'(PATH_DEPTH));
  assign o_rdData   = r_mem[r_rdPtr];
  assign o_rdIsLast = ((CNT_W'(r_rdPtr) + CNT_W'(1)) == r_count);
  assign o_ovf      = r_ovf;

  // Hops beyond capacity are dropped but flagged so the report is known to be truncated.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < PATH_DEPTH; i++) r_mem[i] <= '0;
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (i_wrEn) begin
        if (w_full) begin
          r_ovf <= 1'b1;
        end else begin
          r_mem[r_wrPtr] <= i_wrData;
          r_wrPtr        <= r_wrPtr + PTR_W'(1);
          r_count        <= r_count + CNT_W'(1);
        end
      end
      if (i_rdAdv && !o_rdIsLast) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/iq_capture_hls_deadlock_report_unit.sv
// Global deadlock collector: elects an origin, follows the token walk back to
// it (or times out) and streams the recorded cycle path on the report port.
module iq_capture_hls_deadlock_report_unit
  import iq_capture_dl_pkg::*;
#(
  parameter int PROC_NUM   = 4,
  parameter int PATH_DEPTH = 8,
  parameter int TIMEOUT    = 255,
  parameter int ID_W       = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PROC_NUM-1:0] dl_in_vec,
  input  logic [PROC_NUM-1:0] token_vec,
  output logic                dl_detect,
  output logic [PROC_NUM-1:0] origin_vec,
  output logic                token_clear,
  output logic                rpt_vld,
  input  logic                rpt_rdy,
  output logic [ID_W-1:0]     rpt_id,
  output logic                rpt_last,
  output logic                rpt_timeout,
  output logic                rpt_ovf,
  output logic                done
);

  localparam int CNT_W = clog2_min1(TIMEOUT + 1);

  dl_state_t        r_state;
  dl_state_t        w_nextState;
  logic [ID_W-1:0]  r_origId;
  logic [CNT_W-1:0] r_walkCnt;
  logic             r_timeout;

  logic [ID_W-1:0]  w_dlLow;
  logic [ID_W-1:0]  w_tokLow;
  logic             w_returnHit;
  logic             w_timeoutHit;
  logic             w_pathWrEn;
  logic [ID_W-1:0]  w_pathWrData;
  logic             w_rdAdv;
  logic [ID_W-1:0]  w_rdData;
  logic             w_rdIsLast;
  logic             w_ovf;

  assign w_dlLow  = ID_W'(lowest_set_index(MAX_VEC_W'(dl_in_vec)));
  assign w_tokLow = ID_W'(lowest_set_index(MAX_VEC_W'(token_vec)));

  // The first WALK cycle is excluded from return detection: the origin's own
  // request may still be visible there and is not a returning token.
  assign w_returnHit  = (r_state == ST_WALK) && (r_walkCnt != '0) && dl_in_vec[r_origId];
  assign w_timeoutHit = (r_state == ST_WALK) && !w_returnHit &&
                        (r_walkCnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    w_nextState  = r_state;
    w_pathWrEn   = 1'b0;
    w_pathWrData = '0;
    origin_vec   = '0;
    token_clear  = 1'b0;
    rpt_vld      = 1'b0;
    done         = 1'b0;
    dl_detect    = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        if (dl_in_vec != '0) w_nextState = ST_ORIGIN;
      end
      ST_ORIGIN: begin
        origin_vec   = PROC_NUM'(1) << r_origId;
        w_pathWrEn   = 1'b1;
        w_pathWrData = r_origId;
        w_nextState  = ST_WALK;
      end
      ST_WALK: begin
        w_pathWrEn   = (token_vec != '0);
        w_pathWrData = w_tokLow;
        token_clear  = w_returnHit;
        if (w_returnHit || w_timeoutHit) w_nextState = ST_REPORT;
      end
      ST_REPORT: begin
        rpt_vld = 1'b1;
        if (rpt_rdy && w_rdIsLast) w_nextState = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_origId  <= '0;
      r_walkCnt <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (r_state == ST_IDLE && dl_in_vec != '0) r_origId <= w_dlLow;
      if (r_state == ST_ORIGIN) r_walkCnt <= '0;
      if (r_state == ST_WALK && r_walkCnt != CNT_W'(TIMEOUT)) begin
        r_walkCnt <= r_walkCnt + CNT_W'(1);
      end
      if (w_timeoutHit) r_timeout <= 1'b1;
    end
  end

  assign w_rdAdv     = rpt_vld & rpt_rdy;
  assign rpt_id      = w_rdData;
  assign rpt_last    = rpt_vld & w_rdIsLast;
  assign rpt_timeout = r_timeout;
  assign rpt_ovf     = w_ovf;

  iq_capture_dl_path_buf #(
    .PATH_DEPTH(PATH_DEPTH),
    .ID_W      (ID_W)
  ) u_pathBuf (
    .clock     (clock),
    .reset     (reset),
    .i_wrEn    (w_pathWrEn),
    .i_wrData  (w_pathWrData),
    .i_rdAdv   (w_rdAdv),
    .o_rdData  (w_rdData),
    .o_rdIsLast(w_rdIsLast),
    .o_ovf     (w_ovf)
  );

endmodule

// File: tb/tb_iq_capture_hls_deadlock_report_unit.sv
// Directed bench for the deadlock report unit: loop walk, simultaneous
// requests, backpressure, timeout, overflow and mid-operation reset.
module tb_iq_capture_hls_deadlock_report_unit;

  logic       clock;
  logic       reset;
  logic [3:0] dl_in_vec;
  logic [3:0] token_vec;
  logic       dl_detect;
  logic [3:0] origin_vec;
  logic       token_clear;
  logic       rpt_vld;
  logic       rpt_rdy;
  logic [1:0] rpt_id;
  logic       rpt_last;
  logic       rpt_timeout;
  logic       rpt_ovf;
  logic       done;

  int compCnt = 0;
  int errCnt  = 0;

  iq_capture_hls_deadlock_report_unit #(
    .PROC_NUM  (4),
    .PATH_DEPTH(8),
    .TIMEOUT   (255),
    .ID_W      (2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .dl_in_vec  (dl_in_vec),
    .token_vec  (token_vec),
    .dl_detect  (dl_detect),
    .origin_vec (origin_vec),
    .token_clear(token_clear),
    .rpt_vld    (rpt_vld),
    .rpt_rdy    (rpt_rdy),
    .rpt_id     (rpt_id),
    .rpt_last   (rpt_last),
    .rpt_timeout(rpt_timeout),
    .rpt_ovf    (rpt_ovf),
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] dl, input logic [3:0] tok, input logic rdy);
    dl_in_vec = dl;
    token_vec = tok;
    rpt_rdy   = rdy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compCnt++;
    assert (observed === expected) else begin
      errCnt++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_dl_detect"}, 32'(dl_detect), 0);
    checkOutput({tag, "_origin"}, 32'(origin_vec), 0);
    checkOutput({tag, "_tclear"}, 32'(token_clear), 0);
    checkOutput({tag, "_vld"}, 32'(rpt_vld), 0);
    checkOutput({tag, "_id"}, 32'(rpt_id), 0);
    checkOutput({tag, "_last"}, 32'(rpt_last), 0);
    checkOutput({tag, "_to"}, 32'(rpt_timeout), 0);
    checkOutput({tag, "_ovf"}, 32'(rpt_ovf), 0);
    checkOutput({tag, "_done"}, 32'(done), 0);
  endtask

  task automatic doReset(input string tag);
    reset = 1'b0;
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    tick();
    checkAllZero(tag);
    reset = 1'b1;
  endtask

  // Checks one report beat with rpt_rdy already high, then consumes it.
  task automatic expectBeat(input string tag, input logic [1:0] id, input logic last,
                            input logic to, input logic ovf);
    checkOutput({tag, "_vld"}, 32'(rpt_vld), 1);
    checkOutput({tag, "_id"}, 32'(rpt_id), 32'(id));
    checkOutput({tag, "_last"}, 32'(rpt_last), 32'(last));
    checkOutput({tag, "_to"}, 32'(rpt_timeout), 32'(to));
    checkOutput({tag, "_ovf"}, 32'(rpt_ovf), 32'(ovf));
    tick();
  endtask

  initial begin
    logic [1:0] ovfPath [8];
    logic [3:0] tok;
    int         walkCycles;
    logic       sawClear;

    reset = 1'b0;
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    tick();
    tick();
    checkAllZero("reset");
    reset = 1'b1;

    // Simple loop: origin 2, tokens visit 0, 3, 2
    applyStimulus(4'b0100, 4'b0000, 1'b1);
    tick();
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkOutput("t1_origin", 32'(origin_vec), 32'h4);
    checkOutput("t1_dl_detect", 32'(dl_detect), 1);
    tick();
    applyStimulus(4'b0000, 4'b0001, 1'b1);
    checkOutput("t1_w0_tclear", 32'(token_clear), 0);
    checkOutput("t1_w0_origin", 32'(origin_vec), 0);
    tick();
    applyStimulus(4'b0000, 4'b1000, 1'b1);
    tick();
    applyStimulus(4'b0100, 4'b0100, 1'b1);
    checkOutput("t1_ret_tclear", 32'(token_clear), 1);
    tick();
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    expectBeat("t1_b0", 2'd2, 1'b0, 1'b0, 1'b0);
    expectBeat("t1_b1", 2'd0, 1'b0, 1'b0, 1'b0);
    expectBeat("t1_b2", 2'd3, 1'b0, 1'b0, 1'b0);
    expectBeat("t1_b3", 2'd2, 1'b1, 1'b0, 1'b0);
    checkOutput("t1_done", 32'(done), 1);
    checkOutput("t1_done_vld", 32'(rpt_vld), 0);
    checkOutput("t1_done_dl", 32'(dl_detect), 1);
    applyStimulus(4'b1111, 4'b1111, 1'b1);
    tick();
    checkOutput("t1_hold_done", 32'(done), 1);
    checkOutput("t1_hold_origin", 32'(origin_vec), 0);
    checkOutput("t1_hold_tclear", 32'(token_clear), 0);

    // Simultaneous request picks index 1; backpressure mid-report
    doReset("t2_rst");
    applyStimulus(4'b1010, 4'b0000, 1'b1);
    tick();
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkOutput("t2_origin", 32'(origin_vec), 32'h2);
    tick();
    applyStimulus(4'b0010, 4'b0100, 1'b1);
    checkOutput("t2_w0_noret", 32'(token_clear), 0);
    tick();
    applyStimulus(4'b1000, 4'b0110, 1'b1);
    checkOutput("t2_other_bit", 32'(token_clear), 0);
    tick();
    applyStimulus(4'b0010, 4'b0000, 1'b1);
    checkOutput("t2_ret_tclear", 32'(token_clear), 1);
    tick();
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    expectBeat("t2_b0", 2'd1, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("t3_stall_vld", 32'(rpt_vld), 1);
      checkOutput("t3_stall_id", 32'(rpt_id), 2);
      checkOutput("t3_stall_last", 32'(rpt_last), 0);
      tick();
    end
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    expectBeat("t3_b1", 2'd2, 1'b0, 1'b0, 1'b0);
    expectBeat("t3_b2", 2'd1, 1'b1, 1'b0, 1'b0);
    checkOutput("t3_done", 32'(done), 1);

    // Timeout: origin 0, one hop to 2, no return
    doReset("t4_rst");
    applyStimulus(4'b0001, 4'b0000, 1'b1);
    tick();
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    tick();
    applyStimulus(4'b0000, 4'b0100, 1'b1);
    sawClear = token_clear;
    walkCycles = 1;
    tick();
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    while (!rpt_vld && walkCycles < 400) begin
      if (token_clear) sawClear = 1'b1;
      walkCycles++;
      tick();
    end
    checkOutput("t4_walk_cycles", 32'(walkCycles), 255);
    checkOutput("t4_no_tclear", 32'(sawClear), 0);
    expectBeat("t4_b0", 2'd0, 1'b0, 1'b1, 1'b0);
    expectBeat("t4_b1", 2'd2, 1'b1, 1'b1, 1'b0);
    checkOutput("t4_done", 32'(done), 1);

    // Overflow: origin 3, ten hops 0,1,2,3,0,1,2,3,0,1 then return
    doReset("t5_rst");
    ovfPath = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
    applyStimulus(4'b1000, 4'b0000, 1'b1);
    tick();
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    tick();
    for (int i = 0; i < 10; i++) begin
      tok = 4'b0001 << (i % 4);
      applyStimulus(4'b0000, tok, 1'b1);
      tick();
    end
    applyStimulus(4'b1000, 4'b0000, 1'b1);
    checkOutput("t5_ret_tclear", 32'(token_clear), 1);
    tick();
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    for (int k = 0; k < 8; k++) begin
      expectBeat("t5_beat", ovfPath[k], (k == 7), 1'b0, 1'b1);
    end
    checkOutput("t5_done", 32'(done), 1);

    // Reset during WALK, then during REPORT
    doReset("t6_rst");
    applyStimulus(4'b0001, 4'b0000, 1'b1);
    tick();
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    tick();
    applyStimulus(4'b0000, 4'b0010, 1'b1);
    tick();
    reset = 1'b0;
    applyStimulus(4'b0001, 4'b0000, 1'b1);
    tick();
    checkAllZero("t6_walk_rst");
    reset = 1'b1;
    applyStimulus(4'b0100, 4'b0000, 1'b1);
    tick();
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkOutput("t6a_origin", 32'(origin_vec), 32'h4);
    tick();
    applyStimulus(4'b0000, 4'b0001, 1'b1);
    tick();
    applyStimulus(4'b0100, 4'b0000, 1'b1);
    checkOutput("t6a_tclear", 32'(token_clear), 1);
    tick();
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    expectBeat("t6a_b0", 2'd2, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    checkAllZero("t6_rpt_rst");
    reset = 1'b1;
    applyStimulus(4'b0001, 4'b0000, 1'b1);
    tick();
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkOutput("t6b_origin", 32'(origin_vec), 32'h1);
    tick();
    tick();
    applyStimulus(4'b0001, 4'b0000, 1'b1);
    checkOutput("t6b_tclear", 32'(token_clear), 1);
    tick();
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    expectBeat("t6b_b0", 2'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("t6b_done", 32'(done), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCnt, errCnt);
    $finish;
  end

endmodule
